// File: rtl/uart_com_ctrl.sv
// uart_com_ctrl: COM-port serial engine behind the memory controller.
// Bytes written by the controller go through a TX FIFO and leave as 8N1 on uart_txd.
// 8N1 frames on uart_rxd go into an RX FIFO whose head byte is shown to the controller.
//
// state   | meaning (shared encoding for the TX and RX FSMs)
// S_IDLE  | line idle; TX waits for FIFO data, RX waits for a low line
// S_START | start bit; TX drives 0, RX waits half a bit then confirms the low level
// S_DATA  | 8 data bits, LSB first
// S_STOP  | stop bit; TX drives 1, RX samples it once and then returns to idle
module uart_com_ctrl #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic [7:0] com_data_out,
  input  logic       enable_com_write,
  output logic       com_write_ready,
  output logic [7:0] com_data_in,
  output logic       com_read_ready,
  input  logic       int_com_ack,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr, tx_rd;
  logic [AW:0]   tx_cnt;
  logic          tx_full, tx_empty, tx_push, tx_pop;

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  // A write into a full FIFO is still taken when the shifter pops in the same cycle.
  assign tx_push  = enable_com_write && (!tx_full || tx_pop);
  assign com_write_ready = !tx_full;

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk50M) begin
    if (rst) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      tx_cnt <= tx_cnt + (AW + 1)'(tx_push) - (AW + 1)'(tx_pop);
    end
  end

  // TX FIFO storage; contents are only meaningful under the pointers
  always_ff @(posedge clk50M) begin
    if (tx_push) tx_mem[tx_wr] <= com_data_out;
  end

  // ---------------- TX FSM ----------------
  uart_state_t   tx_state, tx_state_nxt;
  logic [CW-1:0] tx_timer, tx_timer_nxt;
  logic [2:0]    tx_bit, tx_bit_nxt;
  logic [7:0]    tx_shift, tx_shift_nxt;
  logic          txd_nxt;

  // TX state, bit timer, shifter and the registered line output
  always_ff @(posedge clk50M) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_timer <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_timer <= tx_timer_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
      uart_txd <= txd_nxt;
    end
  end

  // TX next state; the line level is decoded from the next state so it is registered
  always_comb begin
    tx_state_nxt = tx_state;
    tx_timer_nxt = tx_timer;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_pop       = 1'b0;
    case (tx_state)
      S_IDLE: if (!tx_empty) begin
        tx_pop       = 1'b1;
        tx_shift_nxt = tx_mem[tx_rd];
        tx_timer_nxt = BIT_LAST;
        tx_state_nxt = S_START;
      end
      S_START: if (tx_timer == '0) begin
        tx_timer_nxt = BIT_LAST;
        tx_bit_nxt   = '0;
        tx_state_nxt = S_DATA;
      end else tx_timer_nxt = tx_timer - 1'b1;
      S_DATA: if (tx_timer == '0) begin
        tx_timer_nxt = BIT_LAST;
        if (tx_bit == 3'd7) tx_state_nxt = S_STOP;
        else begin
          tx_bit_nxt   = tx_bit + 1'b1;
          tx_shift_nxt = {1'b0, tx_shift[7:1]};
        end
      end else tx_timer_nxt = tx_timer - 1'b1;
      S_STOP: if (tx_timer == '0) tx_state_nxt = S_IDLE;
              else tx_timer_nxt = tx_timer - 1'b1;
      default: tx_state_nxt = S_IDLE;
    endcase
    txd_nxt = 1'b1;
    if (tx_state_nxt == S_START)     txd_nxt = 1'b0;
    else if (tx_state_nxt == S_DATA) txd_nxt = tx_shift_nxt[0];
  end

  // ---------------- RX synchroniser ----------------
  logic rxd_meta, rxd_sync;

  // Two-flop synchroniser; resets to the idle line level
  always_ff @(posedge clk50M) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
    end
  end

  // ---------------- RX FSM ----------------
  uart_state_t   rx_state, rx_state_nxt;
  logic [CW-1:0] rx_timer, rx_timer_nxt;
  logic [2:0]    rx_bit, rx_bit_nxt;
  logic [7:0]    rx_shift, rx_shift_nxt;
  logic          rx_push_req, rx_ferr_nxt;

  // RX state, timer, shifter and the framing-error pulse
  always_ff @(posedge clk50M) begin
    if (rst) begin
      rx_state     <= S_IDLE;
      rx_timer     <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_state     <= rx_state_nxt;
      rx_timer     <= rx_timer_nxt;
      rx_bit       <= rx_bit_nxt;
      rx_shift     <= rx_shift_nxt;
      rx_frame_err <= rx_ferr_nxt;
    end
  end

  // RX next state; a stop sample either pushes the byte or flags a framing error
  always_comb begin
    rx_state_nxt = rx_state;
    rx_timer_nxt = rx_timer;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_push_req  = 1'b0;
    rx_ferr_nxt  = 1'b0;
    case (rx_state)
      S_IDLE: if (!rxd_sync) begin
        rx_timer_nxt = HALF_LAST;
        rx_state_nxt = S_START;
      end
      S_START: if (rx_timer == '0) begin
        rx_timer_nxt = BIT_LAST;
        rx_bit_nxt   = '0;
        rx_state_nxt = rxd_sync ? S_IDLE : S_DATA;
      end else rx_timer_nxt = rx_timer - 1'b1;
      S_DATA: if (rx_timer == '0) begin
        rx_timer_nxt = BIT_LAST;
        rx_shift_nxt = {rxd_sync, rx_shift[7:1]};
        if (rx_bit == 3'd7) rx_state_nxt = S_STOP;
        else rx_bit_nxt = rx_bit + 1'b1;
      end else rx_timer_nxt = rx_timer - 1'b1;
      S_STOP: if (rx_timer == '0) begin
        rx_push_req  = rxd_sync;
        rx_ferr_nxt  = !rxd_sync;
        rx_state_nxt = S_IDLE;
      end else rx_timer_nxt = rx_timer - 1'b1;
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr, rx_rd;
  logic [AW:0]   rx_cnt;
  logic          rx_full, rx_empty, rx_push, rx_pop, ack_q;

  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);
  // Pop on the ack falling edge so the head stays put for the whole CPU read.
  assign rx_pop   = ack_q && !int_com_ack && !rx_empty;
  assign rx_push  = rx_push_req && (!rx_full || rx_pop);
  assign com_read_ready = !rx_empty;
  assign com_data_in    = rx_empty ? 8'h00 : rx_mem[rx_rd];

  // RX FIFO pointers, occupancy, ack edge detect and sticky overrun
  always_ff @(posedge clk50M) begin
    if (rst) begin
      rx_wr      <= '0;
      rx_rd      <= '0;
      rx_cnt     <= '0;
      ack_q      <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      ack_q <= int_com_ack;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      rx_cnt <= rx_cnt + (AW + 1)'(rx_push) - (AW + 1)'(rx_pop);
      if (rx_pop) rx_overrun <= 1'b0;
      else if (rx_push_req && rx_full) rx_overrun <= 1'b1;
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk50M) begin
    if (rx_push) rx_mem[rx_wr] <= rx_shift_nxt;
  end

endmodule

// File: tb/tb_uart_com_ctrl.sv
// Directed bench for uart_com_ctrl at DIV = 16 (CLK_FREQ 1600, BAUD 100).
module tb_uart_com_ctrl;

  logic       clk50M = 1'b0;
  logic       rst;
  logic [7:0] com_data_out;
  logic       enable_com_write;
  logic       com_write_ready;
  logic [7:0] com_data_in;
  logic       com_read_ready;
  logic       int_com_ack;
  logic       uart_rxd;
  logic       uart_txd;
  logic       rx_overrun;
  logic       rx_frame_err;

  int n_pass  = 0;
  int n_total = 0;
  int ferr_cnt = 0;
  int ferr_before;

  uart_com_ctrl #(.CLK_FREQ(1600), .BAUD(100), .FIFO_DEPTH(4)) dut (
    .clk50M(clk50M), .rst(rst),
    .com_data_out(com_data_out), .enable_com_write(enable_com_write),
    .com_write_ready(com_write_ready), .com_data_in(com_data_in),
    .com_read_ready(com_read_ready), .int_com_ack(int_com_ack),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
  );

  always #5 clk50M = ~clk50M;

  // count cycles in which the framing-error flag is high
  always @(posedge clk50M) if (rx_frame_err) ferr_cnt <= ferr_cnt + 1;

  task automatic tick();
    @(posedge clk50M);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  // Walks one TX frame from `off` cycles into its start bit; checks first/last cycle of each bit.
  // Returns on the cycle after the stop bit.
  task automatic tx_frame(input logic [7:0] b, input int off, input string tag);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int c = 0; c < 16; c++)
        if (i > 0 || c >= off) begin
          if (c == 0 || c == 15 || (i == 0 && c == off))
            check(tag, 8'(uart_txd), 8'(fr[i]));
          tick();
        end
  endtask

  // Drives one 8N1 frame on uart_rxd, 16 cycles per bit, then returns the line to idle.
  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = fr[i];
      repeat (16) tick();
    end
    uart_rxd = 1'b1;
  endtask

  task automatic ack_pulse(input int len);
    int_com_ack = 1'b1;
    repeat (len) tick();
    int_com_ack = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; com_data_out = 8'h00; enable_com_write = 1'b0;
    int_com_ack = 1'b0; uart_rxd = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_txd", 8'(uart_txd), 8'h01);
    check("rst_wr_ready", 8'(com_write_ready), 8'h01);
    check("rst_rd_ready", 8'(com_read_ready), 8'h00);
    check("rst_data_in", com_data_in, 8'h00);
    check("rst_overrun", 8'(rx_overrun), 8'h00);
    check("rst_ferr", 8'(rx_frame_err), 8'h00);
    tick();

    // 1: single byte A5, start bit begins two cycles after the write
    enable_com_write = 1'b1; com_data_out = 8'hA5;
    tick();
    enable_com_write = 1'b0;
    check("t1_pre_start", 8'(uart_txd), 8'h01);
    check("t1_wr_ready", 8'(com_write_ready), 8'h01);
    tick();
    tx_frame(8'hA5, 0, "t1_frame_a5");
    check("t1_idle_after", 8'(uart_txd), 8'h01);
    check("t1_wr_ready_after", 8'(com_write_ready), 8'h01);
    repeat (5) tick();

    // 2: five back-to-back writes fill the FIFO, a sixth is dropped
    for (int k = 1; k <= 5; k++) begin
      enable_com_write = 1'b1; com_data_out = 8'(k);
      tick();
    end
    check("t2_full", 8'(com_write_ready), 8'h00);
    com_data_out = 8'h06;
    tick();
    enable_com_write = 1'b0;
    check("t2_full_after_drop", 8'(com_write_ready), 8'h00);
    tx_frame(8'h01, 4, "t2_frame_01");
    check("t2_gap_01", 8'(uart_txd), 8'h01);
    check("t2_still_full", 8'(com_write_ready), 8'h00);
    tick();
    check("t2_not_full", 8'(com_write_ready), 8'h01);
    for (int k = 2; k <= 5; k++) begin
      tx_frame(8'(k), 0, "t2_frame_n");
      check("t2_gap", 8'(uart_txd), 8'h01);
      if (k < 5) tick();
    end
    repeat (20) tick();
    check("t2_no_06", 8'(uart_txd), 8'h01);
    check("t2_wr_ready_end", 8'(com_write_ready), 8'h01);

    // 3: receive 3C, hold ack for 3 cycles, exactly one pop
    rx_send(8'h3C, 1'b1);
    check("t3_rd_ready", 8'(com_read_ready), 8'h01);
    check("t3_data", com_data_in, 8'h3C);
    int_com_ack = 1'b1;
    repeat (3) tick();
    check("t3_hold_during_ack", com_data_in, 8'h3C);
    int_com_ack = 1'b0;
    check("t3_hold_at_fall", com_data_in, 8'h3C);
    tick();
    check("t3_rd_ready_after", 8'(com_read_ready), 8'h00);
    check("t3_data_after", com_data_in, 8'h00);
    repeat (3) tick();
    check("t3_still_empty", 8'(com_read_ready), 8'h00);

    // 4: five frames into a 4-deep FIFO -> overrun
    for (int k = 0; k < 5; k++) rx_send(8'h10 + 8'(k), 1'b1);
    check("t4_rd_ready", 8'(com_read_ready), 8'h01);
    check("t4_head_10", com_data_in, 8'h10);
    check("t4_overrun", 8'(rx_overrun), 8'h01);
    ack_pulse(2);
    check("t4_head_11", com_data_in, 8'h11);
    check("t4_overrun_clr", 8'(rx_overrun), 8'h00);
    ack_pulse(1);
    check("t4_head_12", com_data_in, 8'h12);
    ack_pulse(1);
    check("t4_head_13", com_data_in, 8'h13);
    ack_pulse(1);
    check("t4_empty", 8'(com_read_ready), 8'h00);
    check("t4_empty_data", com_data_in, 8'h00);
    check("t4_no_ferr", 8'(ferr_cnt), 8'h00);

    // 5: bad stop bit, then a short glitch, then a good frame
    ferr_before = ferr_cnt;
    rx_send(8'h77, 1'b0);
    repeat (20) tick();
    check("t5_ferr_one_cycle", 8'(ferr_cnt - ferr_before), 8'h01);
    check("t5_no_push", 8'(com_read_ready), 8'h00);
    uart_rxd = 1'b0;
    repeat (4) tick();
    uart_rxd = 1'b1;
    repeat (200) tick();
    check("t5_glitch_no_push", 8'(com_read_ready), 8'h00);
    check("t5_glitch_no_ferr", 8'(ferr_cnt - ferr_before), 8'h01);
    rx_send(8'hC3, 1'b1);
    check("t5_good_after_glitch", com_data_in, 8'hC3);
    ack_pulse(1);
    check("t5_drained", 8'(com_read_ready), 8'h00);

    // 6: reset in the middle of a TX frame and an RX frame
    rx_send(8'h99, 1'b1);
    check("t6_rx_loaded", 8'(com_read_ready), 8'h01);
    uart_rxd = 1'b0;
    for (int k = 0; k < 5; k++) begin
      enable_com_write = 1'b1; com_data_out = 8'h00;
      tick();
    end
    enable_com_write = 1'b0;
    repeat (25) tick();
    check("t6_tx_in_data", 8'(uart_txd), 8'h00);
    check("t6_tx_full", 8'(com_write_ready), 8'h00);
    rst = 1'b1; uart_rxd = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_txd", 8'(uart_txd), 8'h01);
    check("t6_rst_rd_ready", 8'(com_read_ready), 8'h00);
    check("t6_rst_wr_ready", 8'(com_write_ready), 8'h01);
    check("t6_rst_data", com_data_in, 8'h00);
    repeat (10) tick();
    check("t6_tx_flushed", 8'(uart_txd), 8'h01);
    enable_com_write = 1'b1; com_data_out = 8'h5A;
    tick();
    enable_com_write = 1'b0;
    tick();
    tx_frame(8'h5A, 0, "t6_frame_5a");
    check("t6_idle_after", 8'(uart_txd), 8'h01);
    check("t6_no_rx", 8'(com_read_ready), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
